mask_rev_reader: RTL and testbench

- Reader for the mask-revision nibble display. Drives the 3-bit digit index, waits for the 7-segment pattern to settle, and decodes the pattern back to a hex nibble.
- Reassembles the full 32-bit revision word from the 8 nibbles.
- Sits on a host/tester tile: sel_out connects to the displaying tile's index inputs, and seg_in connects to its segment outputs.

---
 rtl/mask_rev_pkg.sv | 68 ++++++
 rtl/mask_rev_reader_if.sv | 31 +++
 rtl/mask_rev_reader_seg7_decode.sv | 37 +++
 rtl/mask_rev_reader.sv | 125 ++++++++++++
 tb/tb_mask_rev_reader.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mask_rev_pkg.sv
// Shared definitions for the mask-revision nibble display reader.
// Holds the scan FSM states, the 7-segment code table (also used by the
// display-side encoder), word geometry and the scan result payload.
package mask_rev_pkg;

  localparam int unsigned NIBBLES = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned WORD_W  = NIBBLES * NIB_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Segment codes, bit0=a ... bit6=g, active high
  localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h71;

  // Result of one full scan
  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic              err;
    logic [IDX_W-1:0]  err_index;
  } scan_result_t;

  // Nibble to segment pattern, for the display-side encoder
  function automatic logic [SEG_W-1:0] seg_encode(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] code;
    case (nib)
      4'h0: code = SEG_HEX_0;
      4'h1: code = SEG_HEX_1;
      4'h2: code = SEG_HEX_2;
      4'h3: code = SEG_HEX_3;
      4'h4: code = SEG_HEX_4;
      4'h5: code = SEG_HEX_5;
      4'h6: code = SEG_HEX_6;
      4'h7: code = SEG_HEX_7;
      4'h8: code = SEG_HEX_8;
      4'h9: code = SEG_HEX_9;
      4'hA: code = SEG_HEX_A;
      4'hB: code = SEG_HEX_B;
      4'hC: code = SEG_HEX_C;
      4'hD: code = SEG_HEX_D;
      4'hE: code = SEG_HEX_E;
      default: code = SEG_HEX_F;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mask_rev_reader_if.sv
// Bus between a host/tester and the mask-revision reader.
//   start      host -> reader  single-cycle scan request
//   seg_in     display -> reader observed segment pattern
//   sel_out    reader -> display digit index
//   busy/done  reader status, done is a one-cycle pulse
//   rev_out    assembled revision word
//   err        last scan saw an undecodable pattern
//   err_index  first undecodable digit of last scan
interface mask_rev_reader_if;
  import mask_rev_pkg::*;

  logic                start;
  logic [SEG_W-1:0]    seg_in;
  logic [IDX_W-1:0]    sel_out;
  logic                busy;
  logic                done;
  logic [WORD_W-1:0]   rev_out;
  logic                err;
  logic [IDX_W-1:0]    err_index;

  modport master (
    output start, seg_in,
    input  sel_out, busy, done, rev_out, err, err_index
  );

  modport slave (
    input  start, seg_in,
    output sel_out, busy, done, rev_out, err, err_index
  );

endinterface

// File: rtl/mask_rev_reader_seg7_decode.sv
// Combinational 7-segment to hex nibble decoder.
//   seg       observed pattern, bit0=a ... bit6=g
//   nibble_c  decoded value, 0 when the pattern is not a hex digit
//   valid_c   pattern matched one of the 16 hex codes
module seg7_decode
  import mask_rev_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [NIB_W-1:0] nibble_c,
  output logic             valid_c
);

  always_comb begin
    nibble_c = '0;
    valid_c  = 1'b1;
    case (seg)
      SEG_HEX_0: nibble_c = 4'h0;
      SEG_HEX_1: nibble_c = 4'h1;
      SEG_HEX_2: nibble_c = 4'h2;
      SEG_HEX_3: nibble_c = 4'h3;
      SEG_HEX_4: nibble_c = 4'h4;
      SEG_HEX_5: nibble_c = 4'h5;
      SEG_HEX_6: nibble_c = 4'h6;
      SEG_HEX_7: nibble_c = 4'h7;
      SEG_HEX_8: nibble_c = 4'h8;
      SEG_HEX_9: nibble_c = 4'h9;
      SEG_HEX_A: nibble_c = 4'hA;
      SEG_HEX_B: nibble_c = 4'hB;
      SEG_HEX_C: nibble_c = 4'hC;
      SEG_HEX_D: nibble_c = 4'hD;
      SEG_HEX_E: nibble_c = 4'hE;
      SEG_HEX_F: nibble_c = 4'hF;
      default:   valid_c  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mask_rev_reader.sv
// Mask-revision reader: steps the display digit index 0..7, waits
// SETTLE_CYCLES for the segment pattern to settle, decodes each digit and
// publishes the assembled 32-bit word once per scan.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of mask_rev_reader_if
module mask_rev_reader
  import mask_rev_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_DIGITS    = 8
)(
  input  logic              clk,
  input  logic              rst_n,
  mask_rev_reader_if.slave  bus
);

  localparam int unsigned      CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  scan_result_t     shadow_q, shadow_d;
  scan_result_t     result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [NIB_W-1:0] dec_nibble_c;
  logic             dec_valid_c;

  seg7_decode u_decode (
    .seg      (bus.seg_in),
    .nibble_c (dec_nibble_c),
    .valid_c  (dec_valid_c)
  );

  // Scan sequencing, shadow accumulation and registered status
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SETTLE;
          idx_d    = '0;
          cnt_d    = CNT_RELOAD;
          shadow_d = '0;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        shadow_d.word[NIB_W*idx_q +: NIB_W] = dec_valid_c ? dec_nibble_c : '0;
        // Only the first bad digit of a scan is reported
        if (!dec_valid_c && !shadow_q.err) begin
          shadow_d.err       = 1'b1;
          shadow_d.err_index = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETTLE;
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = CNT_RELOAD;
        end
      end

      ST_DONE: begin
        result_d = shadow_q;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Status flops track the state being entered so they align with it
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // sel_out is the digit index itself, so it holds 7 after a scan
  assign bus.sel_out   = idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rev_out   = result_q.word;
  assign bus.err       = result_q.err;
  assign bus.err_index = result_q.err_index;

endmodule

// File: tb/tb_mask_rev_reader.sv
module tb_mask_rev_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mask_rev_reader_if bus_a ();
  mask_rev_reader_if bus_b ();

  mask_rev_reader #(.SETTLE_CYCLES(4), .NUM_DIGITS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

  mask_rev_reader #(.SETTLE_CYCLES(1), .NUM_DIGITS(8)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int total = 0;
  int bad   = 0;

  logic [6:0] enc_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Display responder state
  logic [31:0] resp_word = 32'h0;
  bit          bad_en   [8];
  logic [6:0]  bad_code [8];
  bit          force_en  = 1'b0;
  logic [6:0]  force_val = 7'h00;
  logic [2:0]  h0 = 3'd0, h1 = 3'd0, h2 = 3'd0;

  function automatic logic [6:0] code_for(input logic [2:0] i);
    if (force_en) return force_val;
    if (bad_en[i]) return bad_code[i];
    return enc_tab[resp_word[4*i +: 4]];
  endfunction

  // Instance A sees the index after a delay, instance B immediately
  always @(negedge clk) begin
    h2 = h1;
    h1 = h0;
    h0 = bus_a.sel_out;
    bus_a.seg_in = code_for(h2);
    bus_b.seg_in = code_for(bus_b.sel_out);
  end

  // Reference: decode every digit's pattern by table search
  task automatic model_scan(output logic [31:0] w, output logic e, output logic [2:0] ei);
    w = '0; e = 1'b0; ei = '0;
    for (int i = 0; i < 8; i++) begin
      logic [6:0] c;
      int found;
      c = code_for(3'(i));
      found = -1;
      for (int j = 0; j < 16; j++)
        if (found < 0 && enc_tab[j] == c) found = j;
      if (found >= 0) w[4*i +: 4] = 4'(found);
      else if (!e) begin e = 1'b1; ei = 3'(i); end
    end
  endtask

  task automatic clear_bad();
    for (int i = 0; i < 8; i++) begin bad_en[i] = 1'b0; bad_code[i] = 7'h00; end
  endtask

  // Pulse start and count cycles until done (cycle 1 follows the accepting edge)
  task automatic launch_a(output int cyc, input int budget);
    @(negedge clk); bus_a.start = 1'b1;
    @(posedge clk); #1 bus_a.start = 1'b0;
    cyc = -1;
    for (int n = 1; n <= budget; n++) begin
      if (bus_a.done) begin cyc = n; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic launch_b(output int cyc, input int budget);
    @(negedge clk); bus_b.start = 1'b1;
    @(posedge clk); #1 bus_b.start = 1'b0;
    cyc = -1;
    for (int n = 1; n <= budget; n++) begin
      if (bus_b.done) begin cyc = n; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    force_en = 1'b1; force_val = 7'h7F;
    bus_a.start = 1'b0; bus_b.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus_a.sel_out !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", bus_a.sel_out); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus_a.busy); end
    total++; if (bus_a.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus_a.done); end
    total++; if (bus_a.rev_out !== 32'h0) begin bad++; $display("FAIL reset_rev got=%h exp=0", bus_a.rev_out); end
    total++; if (bus_a.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus_a.err); end
    total++; if (bus_a.err_index !== 3'd0) begin bad++; $display("FAIL reset_erridx got=%0d exp=0", bus_a.err_index); end
    rst_n = 1'b1;
    force_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", bus_a.busy, bus_a.done); end
    total++; if (bus_b.busy !== 1'b0 || bus_b.sel_out !== 3'd0) begin bad++; $display("FAIL idle_after_reset_s1 busy=%b sel=%0d exp=0/0", bus_b.busy, bus_b.sel_out); end
  endtask

  task automatic test_basic();
    logic [31:0] ew; logic ee; logic [2:0] ei;
    resp_word = 32'h1A2B3C4D; clear_bad();
    model_scan(ew, ee, ei);
    @(negedge clk); bus_a.start = 1'b1;
    @(posedge clk); #1 bus_a.start = 1'b0;
    for (int n = 1; n <= 44; n++) begin
      int exp_sel;
      exp_sel = (n <= 40) ? (n - 1) / 5 : 7;
      total++; if (bus_a.sel_out !== 3'(exp_sel)) begin bad++; $display("FAIL basic_sel cyc=%0d got=%0d exp=%0d", n, bus_a.sel_out, exp_sel); end
      total++; if (bus_a.busy !== (n <= 41)) begin bad++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", n, bus_a.busy, (n <= 41)); end
      total++; if (bus_a.done !== (n == 41)) begin bad++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", n, bus_a.done, (n == 41)); end
      if (n <= 41) begin
        total++; if (bus_a.rev_out !== 32'h0) begin bad++; $display("FAIL basic_rev_hold cyc=%0d got=%h exp=0", n, bus_a.rev_out); end
      end else begin
        total++; if (bus_a.rev_out !== ew || bus_a.err !== ee) begin bad++; $display("FAIL basic_rev got=%h/%b exp=%h/%b", bus_a.rev_out, bus_a.err, ew, ee); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_invalid();
    logic [31:0] ew; logic ee; logic [2:0] ei; int cyc;
    resp_word = 32'hFFFFFFFF; clear_bad();
    bad_en[3] = 1'b1; bad_code[3] = 7'h00;
    bad_en[6] = 1'b1; bad_code[6] = 7'h12;
    model_scan(ew, ee, ei);
    launch_a(cyc, 100);
    total++; if (cyc != 41) begin bad++; $display("FAIL invalid_latency got=%0d exp=41", cyc); end
    @(posedge clk); #1;
    total++; if (bus_a.rev_out !== ew) begin bad++; $display("FAIL invalid_rev got=%h exp=%h", bus_a.rev_out, ew); end
    total++; if (bus_a.err !== ee || bus_a.err_index !== ei) begin bad++; $display("FAIL invalid_err got=%b/%0d exp=%b/%0d", bus_a.err, bus_a.err_index, ee, ei); end
    clear_bad();
  endtask

  task automatic test_start_ignored();
    logic [31:0] ew; logic ee; logic [2:0] ei; int dones; int cyc;
    resp_word = $urandom; clear_bad();
    model_scan(ew, ee, ei);
    dones = 0;
    @(negedge clk); bus_a.start = 1'b1;
    @(posedge clk); #1 bus_a.start = 1'b0;
    for (int n = 1; n <= 42; n++) begin
      if (bus_a.done) begin
        dones++;
        total++; if (n != 41) begin bad++; $display("FAIL ignored_done_cycle got=%0d exp=41", n); end
      end
      if (n == 42) begin
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL ignored_busy_c42 got=%b exp=0", bus_a.busy); end
      end
      bus_a.start = (n == 5 || n == 20 || n == 41 || n == 42);
      @(posedge clk); #1;
    end
    bus_a.start = 1'b0;
    total++; if (dones != 1) begin bad++; $display("FAIL ignored_done_count got=%0d exp=1", dones); end
    total++; if (bus_a.rev_out !== ew) begin bad++; $display("FAIL ignored_rev got=%h exp=%h", bus_a.rev_out, ew); end
    total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL ignored_c42_accept busy=%b exp=1", bus_a.busy); end
    cyc = -1;
    for (int m = 1; m <= 60; m++) begin
      if (bus_a.done) begin cyc = m; break; end
      @(posedge clk); #1;
    end
    total++; if (cyc != 41) begin bad++; $display("FAIL ignored_second_latency got=%0d exp=41", cyc); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] ew; logic ee; logic [2:0] ei; int cyc;
    resp_word = 32'h12345678; clear_bad();
    model_scan(ew, ee, ei);
    launch_a(cyc, 100);
    @(posedge clk); #1;
    total++; if (bus_a.rev_out !== ew) begin bad++; $display("FAIL midrst_first_rev got=%h exp=%h", bus_a.rev_out, ew); end
    @(negedge clk); bus_a.start = 1'b1;
    @(posedge clk); #1 bus_a.start = 1'b0;
    repeat (14) @(posedge clk);
    #4;
    total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", bus_a.busy); end
    rst_n = 1'b0;
    #1;
    total++; if (bus_a.rev_out !== 32'h0 || bus_a.err !== 1'b0 || bus_a.err_index !== 3'd0)
      begin bad++; $display("FAIL midrst_result got=%h/%b/%0d exp=0/0/0", bus_a.rev_out, bus_a.err, bus_a.err_index); end
    total++; if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 || bus_a.sel_out !== 3'd0)
      begin bad++; $display("FAIL midrst_status got=%b/%b/%0d exp=0/0/0", bus_a.busy, bus_a.done, bus_a.sel_out); end
    @(negedge clk); rst_n = 1'b1;
    resp_word = $urandom;
    model_scan(ew, ee, ei);
    launch_a(cyc, 100);
    total++; if (cyc != 41) begin bad++; $display("FAIL midrst_latency got=%0d exp=41", cyc); end
    @(posedge clk); #1;
    total++; if (bus_a.rev_out !== ew || bus_a.err !== ee) begin bad++; $display("FAIL midrst_rev got=%h/%b exp=%h/%b", bus_a.rev_out, bus_a.err, ew, ee); end
  endtask

  task automatic test_settle_boundary();
    logic [31:0] ew; logic ee; logic [2:0] ei; int cyc;
    resp_word = 32'h0; clear_bad();
    model_scan(ew, ee, ei);
    launch_b(cyc, 60);
    total++; if (cyc != 17) begin bad++; $display("FAIL s1_latency got=%0d exp=17", cyc); end
    @(posedge clk); #1;
    total++; if (bus_b.rev_out !== ew || bus_b.err !== ee) begin bad++; $display("FAIL s1_rev got=%h/%b exp=%h/%b", bus_b.rev_out, bus_b.err, ew, ee); end
    for (int k = 0; k < 3; k++) begin
      resp_word = $urandom;
      bad_en[k+2] = 1'b1; bad_code[k+2] = 7'($urandom);
      model_scan(ew, ee, ei);
      launch_b(cyc, 60);
      total++; if (cyc != 17) begin bad++; $display("FAIL s1_rand_latency k=%0d got=%0d exp=17", k, cyc); end
      @(posedge clk); #1;
      total++; if (bus_b.rev_out !== ew || bus_b.err !== ee || bus_b.err_index !== ei)
        begin bad++; $display("FAIL s1_rand k=%0d got=%h/%b/%0d exp=%h/%b/%0d", k, bus_b.rev_out, bus_b.err, bus_b.err_index, ew, ee, ei); end
      clear_bad();
    end
  endtask

  task automatic test_random();
    logic [31:0] ew; logic ee; logic [2:0] ei; int cyc;
    for (int k = 0; k < 6; k++) begin
      resp_word = $urandom;
      for (int i = 0; i < 8; i++) begin
        bad_en[i]   = ($urandom_range(0, 3) == 0);
        bad_code[i] = 7'($urandom);
      end
      model_scan(ew, ee, ei);
      launch_a(cyc, 100);
      total++; if (cyc != 41) begin bad++; $display("FAIL rand_latency k=%0d got=%0d exp=41", k, cyc); end
      @(posedge clk); #1;
      total++; if (bus_a.rev_out !== ew || bus_a.err !== ee || bus_a.err_index !== ei)
        begin bad++; $display("FAIL rand_scan k=%0d got=%h/%b/%0d exp=%h/%b/%0d", k, bus_a.rev_out, bus_a.err, bus_a.err_index, ew, ee, ei); end
    end
    clear_bad();
  endtask

  initial begin
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    clear_bad();
    test_reset();
    test_basic();
    test_invalid();
    test_start_ignored();
    test_reset_mid();
    test_settle_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
